uart_baud_gen: RTL

- Runtime-programmable UART baud/oversample tick generator. It is the successor to the fixed-divisor toggling clock generator.
- Produces single-cycle enable pulses (sample_tick, baud_tick, mid_tick) in the clk domain. It does not produce derived clocks.
- Fractional divisor (integer + FRAC_W-bit fraction) via phase accumulator; oversample ratio programmable at runtime.
- Sits between the CSR block and the UART TX/RX engines; one instance can be shared by TX and RX.

---
 rtl/uart_baud_gen_pkg.sv | 30 +++
 rtl/uart_baud_gen_if.sv | 26 ++
 rtl/uart_frac_div.sv | 57 +++++
 rtl/uart_baud_gen.sv | 111 +++++++++++
 4 files changed

// File: rtl/uart_baud_gen_pkg.sv
// Shared widths, limits and configuration payload for the UART baud/oversample tick generator.
package uart_baud_gen_pkg;

    localparam int unsigned OVS_W      = 5;
    localparam int unsigned OVS_MIN    = 4;
    localparam int unsigned OVS_MAX    = 16;
    localparam int unsigned DIV_MIN    = 2;
    localparam int unsigned CFG_DIV_W  = 16;
    localparam int unsigned CFG_FRAC_W = 4;

    typedef struct packed {
        logic [CFG_DIV_W-1:0]  div_int;
        logic [CFG_FRAC_W-1:0] div_frac;
        logic [OVS_W-1:0]      ovs;
    } uart_baud_cfg_t;

    // Reset-default divisor: sys_freq / (baud_rate * sample) in fixed point with CFG_FRAC_W fraction bits.
    function automatic uart_baud_cfg_t default_cfg(input longint unsigned sys_freq,
                                                   input longint unsigned baud_rate,
                                                   input longint unsigned sample);
        longint unsigned q;
        uart_baud_cfg_t  c;
        q          = (sys_freq << CFG_FRAC_W) / (baud_rate * sample);
        c.div_int  = CFG_DIV_W'(q >> CFG_FRAC_W);
        c.div_frac = CFG_FRAC_W'(q);
        c.ovs      = OVS_W'(sample);
        return c;
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Configuration/status and tick bus between the CSR block, the generator and the UART engines.
interface uart_baud_gen_if;
    import uart_baud_gen_pkg::*;

    logic                  en;
    logic                  cfg_we;
    logic [CFG_DIV_W-1:0]  cfg_div_int;
    logic [CFG_FRAC_W-1:0] cfg_div_frac;
    logic [OVS_W-1:0]      cfg_ovs;
    logic                  cfg_pending;
    logic                  cfg_err;
    logic                  sample_tick;
    logic                  baud_tick;
    logic                  mid_tick;

    modport master (
        output en, cfg_we, cfg_div_int, cfg_div_frac, cfg_ovs,
        input  cfg_pending, cfg_err, sample_tick, baud_tick, mid_tick
    );

    modport slave (
        input  en, cfg_we, cfg_div_int, cfg_div_frac, cfg_ovs,
        output cfg_pending, cfg_err, sample_tick, baud_tick, mid_tick
    );

endinterface

// File: rtl/uart_frac_div.sv
// Fractional clock-enable divider: period alternates between div_int and div_int+1 cycles
// so that the long-run mean is div_int + div_frac/2^FRAC_W.
module uart_frac_div #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              tick_c_o
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              extra_q, extra_d;
    logic [DIV_W:0]    last_c;
    logic [FRAC_W:0]   sum_c;
    logic              tick_c;

    // Terminal count is P-1 with P = div_int + extra; one spare bit covers div_int at full scale.
    assign last_c   = {1'b0, div_int_i} + (DIV_W+1)'(extra_q) - (DIV_W+1)'(1);
    assign tick_c   = en_i & ({1'b0, cnt_q} == last_c);
    assign sum_c    = {1'b0, acc_q} + {1'b0, div_frac_i};
    assign tick_c_o = tick_c;

    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        extra_d = extra_q;
        if (!en_i || clr_i) begin
            cnt_d   = '0;
            acc_d   = '0;
            extra_d = 1'b0;
        end else if (tick_c) begin
            cnt_d            = '0;
            {extra_d, acc_d} = sum_c;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            extra_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            extra_q <= extra_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Runtime-programmable UART tick generator: shadowed config with clamping, fractional sample
// divider, and oversample counter decoding baud and bit-centre ticks.
module uart_baud_gen
    import uart_baud_gen_pkg::*;
#(
    parameter int unsigned SYS_FREQ  = 10_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned SAMPLE    = 16,
    parameter int unsigned DIV_W     = CFG_DIV_W,
    parameter int unsigned FRAC_W    = CFG_FRAC_W
) (
    input  logic          clk,
    input  logic          reset_n,
    uart_baud_gen_if.slave bus
);

    localparam uart_baud_cfg_t CFG_RST = default_cfg(64'(SYS_FREQ), 64'(BAUD_RATE), 64'(SAMPLE));

    uart_baud_cfg_t   act_q, act_d;
    uart_baud_cfg_t   shd_q, shd_d;
    uart_baud_cfg_t   wr_cfg_c;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic [OVS_W-1:0] samp_q, samp_d;
    logic [OVS_W-1:0] samp_last_c, samp_mid_c;
    logic             clamp_c;
    logic             apply_c;
    logic             sample_tick_c;

    uart_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_frac_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (bus.en),
        .clr_i      (apply_c),
        .div_int_i  (act_q.div_int),
        .div_frac_i (act_q.div_frac),
        .tick_c_o   (sample_tick_c)
    );

    // Clamp written values into the legal range and flag any correction.
    always_comb begin
        wr_cfg_c = '{div_int: bus.cfg_div_int, div_frac: bus.cfg_div_frac, ovs: bus.cfg_ovs};
        clamp_c  = 1'b0;
        if (bus.cfg_div_int < CFG_DIV_W'(DIV_MIN)) begin
            wr_cfg_c.div_int = CFG_DIV_W'(DIV_MIN);
            clamp_c          = 1'b1;
        end
        if (bus.cfg_ovs < OVS_W'(OVS_MIN)) begin
            wr_cfg_c.ovs = OVS_W'(OVS_MIN);
            clamp_c      = 1'b1;
        end else if (bus.cfg_ovs > OVS_W'(OVS_MAX)) begin
            wr_cfg_c.ovs = OVS_W'(OVS_MAX);
            clamp_c      = 1'b1;
        end
    end

    // While running, swap config only on a sample boundary; while idle, swap immediately.
    assign apply_c = pend_q & (~bus.en | sample_tick_c);

    assign samp_last_c = act_q.ovs - OVS_W'(1);
    assign samp_mid_c  = (act_q.ovs >> 1) - OVS_W'(1);

    always_comb begin
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        err_d  = 1'b0;
        samp_d = samp_q;
        if (apply_c) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
        if (bus.cfg_we) begin
            shd_d  = wr_cfg_c;
            pend_d = 1'b1;
            err_d  = clamp_c;
        end
        if (!bus.en || apply_c) begin
            samp_d = '0;
        end else if (sample_tick_c) begin
            samp_d = (samp_q == samp_last_c) ? '0 : samp_q + OVS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            act_q  <= CFG_RST;
            shd_q  <= CFG_RST;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
            samp_q <= '0;
        end else begin
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            err_q  <= err_d;
            samp_q <= samp_d;
        end
    end

    // The apply tick restarts bit phase, so it is never reported as a bit edge or centre.
    assign bus.sample_tick = sample_tick_c;
    assign bus.baud_tick   = sample_tick_c & ~apply_c & (samp_q == samp_last_c);
    assign bus.mid_tick    = sample_tick_c & ~apply_c & (samp_q == samp_mid_c);
    assign bus.cfg_pending = pend_q;
    assign bus.cfg_err     = err_q;

endmodule
